// File: rtl/bus_pkg.sv
// Shared types and defaults for the two-requester shared-wire arbiter.
package bus_pkg;

  localparam int unsigned HOLD_MAX_DEF = 8;
  localparam int unsigned TURN_CYC_DEF = 1;
  localparam int unsigned CNT_W        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    TURN  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   data;
  } rd_beat_t;

  // Arbitration applied from IDLE and at TURN exit; ties go to the side not served last.
  function automatic arb_state_e arb_pick(input logic req_a, input logic req_b,
                                          input owner_e last);
    arb_state_e st;
    st = IDLE;
    if (req_a && req_b) st = (last == OWNER_B) ? OWN_A : OWN_B;
    else if (req_a)     st = OWN_A;
    else if (req_b)     st = OWN_B;
    return st;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant and read-sample signals between the arbiter and its two requesters.
interface bus_arbiter_if;
  logic req_a;
  logic req_b;
  logic bus_in;
  logic grant_a;
  logic grant_b;
  logic idle;
  logic rd_data;
  logic rd_valid;
  logic rd_owner;
  logic preempt;

  modport slave (
    input  req_a, req_b, bus_in,
    output grant_a, grant_b, idle, rd_data, rd_valid, rd_owner, preempt
  );

  modport master (
    output req_a, req_b, bus_in,
    input  grant_a, grant_b, idle, rd_data, rd_valid, rd_owner, preempt
  );
endinterface

// File: rtl/arb_counter.sv
// Saturating up/down counter with synchronous clear and terminal-count flag.
module arb_counter
  import bus_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         dn_i,
  input  logic [W-1:0] lim_i,
  output logic         tc_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (dn_i) begin
        if (cnt_q != '0) cnt_d = cnt_q - W'(1);
      end else if (cnt_q < lim_i) begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_c = dn_i ? (cnt_q == '0) : (cnt_q == lim_i);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for one shared wire: hold limit, turnaround gap,
// and a registered sample of the wire while it is owned.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF,
  parameter int unsigned TURN_CYC = TURN_CYC_DEF
) (
  input  logic         hz100,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] TURN_LIM = CNT_W'(TURN_CYC - 1);

  arb_state_e state_q, state_d;
  owner_e     last_q, last_d;
  logic       preempt_q, preempt_d;
  logic       grant_a_q, grant_b_q, idle_q;
  logic       rd_valid_q;
  rd_beat_t   rd_q;
  logic       hold_clr, hold_en, hold_tc;
  logic       turn_clr, turn_en, turn_tc;
  logic       own;

  assign own = (state_q == OWN_A) || (state_q == OWN_B);

  arb_counter #(.W(CNT_W)) u_hold (
    .clk   (hz100),
    .rst_n (reset),
    .clr_i (hold_clr),
    .en_i  (hold_en),
    .dn_i  (1'b0),
    .lim_i (HOLD_LIM),
    .tc_c  (hold_tc)
  );

  arb_counter #(.W(CNT_W)) u_turn (
    .clk   (hz100),
    .rst_n (reset),
    .clr_i (turn_clr),
    .en_i  (turn_en),
    .dn_i  (1'b0),
    .lim_i (TURN_LIM),
    .tc_c  (turn_tc)
  );

  // Next state; a release on the hold-limit cycle takes priority over preemption.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    preempt_d = 1'b0;
    hold_clr  = 1'b0;
    turn_clr  = 1'b0;
    hold_en   = own;
    turn_en   = (state_q == TURN);
    case (state_q)
      IDLE: state_d = arb_pick(bus.req_a, bus.req_b, last_q);
      OWN_A: begin
        if (!bus.req_a) begin
          state_d = TURN;
        end else if (hold_tc && bus.req_b) begin
          state_d   = TURN;
          preempt_d = 1'b1;
        end
      end
      OWN_B: begin
        if (!bus.req_b) begin
          state_d = TURN;
        end else if (hold_tc && bus.req_a) begin
          state_d   = TURN;
          preempt_d = 1'b1;
        end
      end
      TURN: if (turn_tc) state_d = arb_pick(bus.req_a, bus.req_b, last_q);
      default: state_d = IDLE;
    endcase
    if (state_d == OWN_A && state_q != OWN_A) begin
      last_d   = OWNER_A;
      hold_clr = 1'b1;
    end
    if (state_d == OWN_B && state_q != OWN_B) begin
      last_d   = OWNER_B;
      hold_clr = 1'b1;
    end
    if (state_d == TURN && state_q != TURN) turn_clr = 1'b1;
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= OWNER_B;
      preempt_q <= 1'b0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      preempt_q <= preempt_d;
      grant_a_q <= (state_d == OWN_A);
      grant_b_q <= (state_d == OWN_B);
      idle_q    <= (state_d == IDLE) || (state_d == TURN);
    end
  end

  // Wire sample taken only while someone owns it; holds otherwise.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= own;
      if (own) rd_q <= '{owner: (state_q == OWN_B) ? OWNER_B : OWNER_A, data: bus.bus_in};
    end
  end

  assign bus.grant_a  = grant_a_q;
  assign bus.grant_b  = grant_b_q;
  assign bus.idle     = idle_q;
  assign bus.preempt  = preempt_q;
  assign bus.rd_data  = rd_q.data;
  assign bus.rd_owner = rd_q.owner;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: ownership-level reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_bus_arbiter;

  localparam int HOLD_MAX = 8;
  localparam int TURN_CYC = 1;

  logic clk;
  logic rst_n;
  bus_arbiter_if bif ();

  bus_arbiter #(.HOLD_MAX(HOLD_MAX), .TURN_CYC(TURN_CYC)) dut (
    .hz100 (clk),
    .reset (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic run_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the wire, how long, how much gap is left.
  int   m_owner, m_held, m_turn_left, m_last;   // owner: 0 none, 1 A, 2 B
  logic m_mine, m_other;
  logic e_ga, e_gb, e_idle, e_rdv, e_rdd, e_rdo, e_pre;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_held = 0; m_turn_left = 0; m_last = 2;
      e_ga = 0; e_gb = 0; e_idle = 1; e_rdv = 0; e_rdd = 0; e_rdo = 0; e_pre = 0;
    end else begin
      e_pre = 1'b0;
      e_rdv = (m_owner != 0);
      if (m_owner != 0) begin
        e_rdd = bif.bus_in;
        e_rdo = (m_owner == 2);
        m_mine  = (m_owner == 1) ? bif.req_a : bif.req_b;
        m_other = (m_owner == 1) ? bif.req_b : bif.req_a;
        m_held++;
        if (!m_mine) begin
          m_owner = 0; m_turn_left = TURN_CYC;
        end else if (m_held >= HOLD_MAX && m_other) begin
          m_owner = 0; m_turn_left = TURN_CYC; e_pre = 1'b1;
        end
      end else begin
        if (m_turn_left > 0) m_turn_left--;
        if (m_turn_left == 0) begin
          if (bif.req_a && bif.req_b) m_owner = (m_last == 1) ? 2 : 1;
          else if (bif.req_a)         m_owner = 1;
          else if (bif.req_b)         m_owner = 2;
          if (m_owner != 0) begin m_last = m_owner; m_held = 0; end
        end
      end
      e_ga   = (m_owner == 1);
      e_gb   = (m_owner == 2);
      e_idle = (m_owner == 0);
    end
  end

  // Per-cycle compare plus mutual-exclusion and handover-gap checks.
  int prev_own = 0, last_own = 0, idle_run = 0, handovers = 0, cur;
  always @(negedge clk) begin
    if (run_chk) begin
      check("grant_a",  32'(bif.grant_a),  32'(e_ga));
      check("grant_b",  32'(bif.grant_b),  32'(e_gb));
      check("idle",     32'(bif.idle),     32'(e_idle));
      check("preempt",  32'(bif.preempt),  32'(e_pre));
      check("rd_valid", 32'(bif.rd_valid), 32'(e_rdv));
      check("rd_data",  32'(bif.rd_data),  32'(e_rdd));
      check("rd_owner", 32'(bif.rd_owner), 32'(e_rdo));
      check("mutex",    32'(bif.grant_a & bif.grant_b), 32'd0);
      cur = bif.grant_a ? 1 : (bif.grant_b ? 2 : 0);
      if (!rst_n) begin
        last_own = 0; idle_run = 0;
      end else begin
        if (cur != 0 && cur != prev_own && last_own != 0)
          check("handover_gap", 32'(prev_own == 0 && idle_run >= TURN_CYC), 32'd1);
        if (cur != 0 && last_own != 0 && cur != last_own) handovers++;
        idle_run = (cur == 0) ? idle_run + 1 : 0;
        if (cur != 0) last_own = cur;
      end
      prev_own = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [3:0] bits;
  int         ho_base;

  initial begin
    rst_n = 1'b1;
    bif.req_a = 1'b0; bif.req_b = 1'b0; bif.bus_in = 1'b0;
    #1 rst_n = 1'b0;
    #1 run_chk = 1'b1;
    tick(); tick();
    check("rst_grant_a",  32'(bif.grant_a),  32'd0);
    check("rst_grant_b",  32'(bif.grant_b),  32'd0);
    check("rst_idle",     32'(bif.idle),     32'd1);
    check("rst_rd_valid", 32'(bif.rd_valid), 32'd0);
    check("rst_rd_data",  32'(bif.rd_data),  32'd0);
    check("rst_preempt",  32'(bif.preempt),  32'd0);

    // Tie after reset: A first, preempted after HOLD_MAX cycles, one TURN, then B.
    rst_n = 1'b1; bif.req_a = 1'b1; bif.req_b = 1'b1;
    tick();
    check("tie_grant_a", 32'(bif.grant_a), 32'd1);
    check("tie_grant_b", 32'(bif.grant_b), 32'd0);
    repeat (7) tick();
    check("hold8_grant_a", 32'(bif.grant_a), 32'd1);
    check("hold8_preempt", 32'(bif.preempt), 32'd0);
    tick();
    check("pre_pulse",   32'(bif.preempt), 32'd1);
    check("pre_grant_a", 32'(bif.grant_a), 32'd0);
    check("pre_idle",    32'(bif.idle),    32'd1);
    tick();
    check("turn_grant_b", 32'(bif.grant_b), 32'd1);
    check("turn_preempt", 32'(bif.preempt), 32'd0);
    bif.req_a = 1'b0; bif.req_b = 1'b0;
    repeat (3) tick();
    check("quiet_idle", 32'(bif.idle), 32'd1);

    // Lone requester holds indefinitely; hold count saturates.
    bif.req_a = 1'b1;
    tick();
    for (int i = 0; i < 50; i++) begin
      tick();
      check("solo_grant_a", 32'(bif.grant_a), 32'd1);
      check("solo_preempt", 32'(bif.preempt), 32'd0);
    end
    check("hold_saturate", 32'(dut.u_hold.cnt_q), 32'd7);
    bif.req_a = 1'b0;
    repeat (3) tick();

    // Wire samples 1,0,1,1 under A, then no valid during TURN.
    bif.req_a = 1'b1;
    tick();
    bits = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      bif.bus_in = bits[3-i];
      tick();
      check("rd_beat_data",  32'(bif.rd_data),  32'(bits[3-i]));
      check("rd_beat_valid", 32'(bif.rd_valid), 32'd1);
      check("rd_beat_owner", 32'(bif.rd_owner), 32'd0);
    end
    bif.req_a = 1'b0;
    tick();
    check("rel_grant_a", 32'(bif.grant_a), 32'd0);
    tick();
    check("turn_rd_valid", 32'(bif.rd_valid), 32'd0);
    bif.bus_in = 1'b0;
    tick();

    // B releases on its last allowed cycle while A waits: release, not preempt.
    bif.req_b = 1'b1;
    tick();
    check("b_grant", 32'(bif.grant_b), 32'd1);
    bif.req_a = 1'b1;
    repeat (7) tick();
    check("b_hold_grant", 32'(bif.grant_b), 32'd1);
    bif.req_b = 1'b0;
    tick();
    check("edge_rel_grant_b", 32'(bif.grant_b), 32'd0);
    check("edge_rel_preempt", 32'(bif.preempt), 32'd0);
    check("edge_rel_idle",    32'(bif.idle),    32'd1);
    tick();
    check("edge_rel_grant_a", 32'(bif.grant_a), 32'd1);
    bif.req_a = 1'b0;
    repeat (3) tick();

    // Reset mid-grant drops grants at once; A wins the first tie afterwards.
    bif.req_b = 1'b1;
    tick();
    repeat (2) tick();
    check("pre_rst_grant_b", 32'(bif.grant_b), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_grant_b", 32'(bif.grant_b), 32'd0);
    check("async_grant_a", 32'(bif.grant_a), 32'd0);
    check("async_idle",    32'(bif.idle),    32'd1);
    bif.req_a = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_grant_a", 32'(bif.grant_a), 32'd1);
    check("post_rst_grant_b", 32'(bif.grant_b), 32'd0);
    bif.req_a = 1'b0; bif.req_b = 1'b0;
    repeat (3) tick();

    // Sustained contention with occasional dropouts.
    ho_base = handovers;
    for (int i = 0; i < 100; i++) begin
      bif.req_a  = (i % 17) != 16;
      bif.req_b  = (i % 13) != 12;
      bif.bus_in = i[0] ^ i[2];
      tick();
    end
    check("contention_handovers", 32'(handovers - ho_base >= 8), 32'd1);
    bif.req_a = 1'b0; bif.req_b = 1'b0;
    repeat (4) tick();

    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
